multicycle_control_fsm: RTL and testbench

Main control unit of the multi-cycle CPU. It sits directly upstream of the main ALU and drives its 4-bit ALU operation code and operand-select muxes. It sequences fetch, decode, execute, memory and writeback for each instruction. It also consumes the ALU zero flag to resolve branches.

---
 rtl/multicycle_control_fsm.sv | 148 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multi-cycle CPU: sequences fetch/decode/execute/memory/writeback
// and drives the ALU opcode and operand muxes. Outputs are registered from the next state.
module multicycle_control_fsm #(
  parameter int RESET_STATE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [3:0] alu_control,
  output logic       illegal_instr,
  output logic [3:0] state_out
);

  // state_out encoding follows the order states are listed: S_RST=0 ... ILLEGAL=13
  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  localparam int CW = (RESET_STATE_CYCLES > 1) ? $clog2(RESET_STATE_CYCLES) : 1;

  state_t        state, nxt;
  logic [CW-1:0] rst_cnt;
  logic          rst_done;
  logic          pc_write, branch;
  logic          funct_ok, funct_shift;
  logic [3:0]    funct_alu;

  logic       d_iord, d_mem_write, d_ir_write, d_reg_dst, d_mem_to_reg, d_reg_write;
  logic       d_pc_write, d_branch, d_illegal;
  logic [1:0] d_src_a, d_src_b, d_pc_src;
  logic [3:0] d_alu;

  assign rst_done = (int'(rst_cnt) >= RESET_STATE_CYCLES - 1);

  always_comb begin
    funct_ok    = 1'b1;
    funct_shift = 1'b0;
    funct_alu   = 4'b0000;
    case (funct)
      6'b100000: funct_alu = 4'b0000;
      6'b100010: funct_alu = 4'b0001;
      6'b011000: funct_alu = 4'b0010;
      6'b011010: funct_alu = 4'b0011;
      6'b100110: funct_alu = 4'b0100;
      6'b100100: funct_alu = 4'b0101;
      6'b100101: funct_alu = 4'b0110;
      6'b101111: funct_alu = 4'b0111;
      6'b100111: funct_alu = 4'b1000;
      6'b101010: funct_alu = 4'b1001;
      6'b000000: begin funct_alu = 4'b1010; funct_shift = 1'b1; end
      6'b000010: begin funct_alu = 4'b1011; funct_shift = 1'b1; end
      6'b000011: begin funct_alu = 4'b1100; funct_shift = 1'b1; end
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_RST:    nxt = rst_done ? S_FETCH : S_RST;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          6'b100011, 6'b101011: nxt = S_MEMADR;
          6'b000000:            nxt = S_EXECUTE;
          6'b000100:            nxt = S_BRANCH;
          6'b001000:            nxt = S_ADDIEXEC;
          6'b000010:            nxt = S_JUMP;
          default:              nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   nxt = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    nxt = S_MEMWB;
      S_EXECUTE:  nxt = funct_ok ? S_ALUWB : S_ILLEGAL;
      S_ADDIEXEC: nxt = S_ADDIWB;
      default:    nxt = S_FETCH;
    endcase
  end

  // Moore decode of the state being entered, so the registers hold this state's outputs
  always_comb begin
    d_iord = 1'b0; d_mem_write = 1'b0; d_ir_write = 1'b0; d_reg_dst = 1'b0;
    d_mem_to_reg = 1'b0; d_reg_write = 1'b0; d_pc_write = 1'b0; d_branch = 1'b0;
    d_illegal = 1'b0; d_src_a = 2'b00; d_src_b = 2'b00; d_pc_src = 2'b00; d_alu = 4'b0000;
    case (nxt)
      S_FETCH:    begin d_ir_write = 1'b1; d_src_b = 2'b01; d_pc_write = 1'b1; end
      S_DECODE:   d_src_b = 2'b11;
      S_MEMADR:   begin d_src_a = 2'b01; d_src_b = 2'b10; end
      S_MEMRD:    d_iord = 1'b1;
      S_MEMWB:    begin d_mem_to_reg = 1'b1; d_reg_write = 1'b1; end
      S_MEMWR:    begin d_iord = 1'b1; d_mem_write = 1'b1; end
      S_EXECUTE:  begin d_alu = funct_alu; d_src_a = funct_shift ? 2'b10 : 2'b01; end
      S_ALUWB:    begin d_reg_dst = 1'b1; d_reg_write = 1'b1; end
      S_BRANCH:   begin d_src_a = 2'b01; d_alu = 4'b0001; d_pc_src = 2'b01; d_branch = 1'b1; end
      S_ADDIEXEC: begin d_src_a = 2'b01; d_src_b = 2'b10; end
      S_ADDIWB:   d_reg_write = 1'b1;
      S_JUMP:     begin d_pc_src = 2'b10; d_pc_write = 1'b1; end
      S_ILLEGAL:  d_illegal = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST; rst_cnt <= '0;
      iord <= 1'b0; mem_write <= 1'b0; ir_write <= 1'b0; reg_dst <= 1'b0;
      mem_to_reg <= 1'b0; reg_write <= 1'b0; pc_write <= 1'b0; branch <= 1'b0;
      illegal_instr <= 1'b0; alu_src_a <= 2'b00; alu_src_b <= 2'b00;
      pc_src <= 2'b00; alu_control <= 4'b0000;
    end else begin
      state   <= nxt;
      rst_cnt <= (state == S_RST && !rst_done) ? rst_cnt + CW'(1) : '0;
      iord <= d_iord; mem_write <= d_mem_write; ir_write <= d_ir_write; reg_dst <= d_reg_dst;
      mem_to_reg <= d_mem_to_reg; reg_write <= d_reg_write; pc_write <= d_pc_write;
      branch <= d_branch; illegal_instr <= d_illegal; alu_src_a <= d_src_a;
      alu_src_b <= d_src_b; pc_src <= d_pc_src; alu_control <= d_alu;
    end
  end

  assign pc_en     = pc_write | (branch & zero);
  assign state_out = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instruction table, random instructions checked
// against a per-instruction path model, and hand-written reset corner cases.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic       zero = 1'b0;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, pc_en, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic [3:0] alu_control, state_out;

  int checks = 0;
  int errors = 0;

  localparam int ST_RST = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3, ST_MEMRD = 4,
                 ST_MEMWB = 5, ST_MEMWR = 6, ST_EXECUTE = 7, ST_ALUWB = 8, ST_BRANCH = 9,
                 ST_ADDIEXEC = 10, ST_ADDIWB = 11, ST_JUMP = 12, ST_ILLEGAL = 13;

  localparam logic [5:0] FN_CODE [13] = '{6'b100000, 6'b100010, 6'b011000, 6'b011010,
    6'b100110, 6'b100100, 6'b100101, 6'b101111, 6'b100111, 6'b101010, 6'b000000,
    6'b000010, 6'b000011};
  localparam logic [3:0] FN_ALU [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
    4'd8, 4'd9, 4'd10, 4'd11, 4'd12};

  multicycle_control_fsm #(.RESET_STATE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .alu_control(alu_control),
    .illegal_instr(illegal_instr), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // {state, alu, src_a, src_b, pc_src, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, pc_en, illegal}
  logic [21:0] act;
  assign act = {state_out, alu_control, alu_src_a, alu_src_b, pc_src, iord, mem_write,
                ir_write, reg_dst, mem_to_reg, reg_write, pc_en, illegal_instr};

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         ill;
  } vec_t;

  int path_q[$];

  function automatic bit fn_lookup(input logic [5:0] f, output logic [3:0] a);
    a = 4'd0;
    for (int i = 0; i < 13; i++)
      if (FN_CODE[i] == f) begin a = FN_ALU[i]; return 1'b1; end
    return 1'b0;
  endfunction

  // Sequence of states an instruction visits from FETCH until the next FETCH
  function automatic void build_path(input logic [5:0] o, input logic [5:0] f);
    logic [3:0] a;
    path_q = '{ST_FETCH, ST_DECODE};
    case (o)
      6'b100011: begin path_q.push_back(ST_MEMADR); path_q.push_back(ST_MEMRD); path_q.push_back(ST_MEMWB); end
      6'b101011: begin path_q.push_back(ST_MEMADR); path_q.push_back(ST_MEMWR); end
      6'b000000: begin
        path_q.push_back(ST_EXECUTE);
        path_q.push_back(fn_lookup(f, a) ? ST_ALUWB : ST_ILLEGAL);
      end
      6'b000100: path_q.push_back(ST_BRANCH);
      6'b001000: begin path_q.push_back(ST_ADDIEXEC); path_q.push_back(ST_ADDIWB); end
      6'b000010: path_q.push_back(ST_JUMP);
      default:   path_q.push_back(ST_ILLEGAL);
    endcase
  endfunction

  function automatic logic [21:0] exp_out(input int st, input logic [5:0] f, input logic z);
    logic [3:0] alu = 4'd0;
    logic [1:0] sa = 2'd0, sb = 2'd0, ps = 2'd0;
    logic io = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, pe = 0, ill = 0;
    logic [3:0] st4 = 4'(st);
    case (st)
      ST_FETCH:    begin irw = 1; sb = 2'b01; pe = 1; end
      ST_DECODE:   sb = 2'b11;
      ST_MEMADR:   begin sa = 2'b01; sb = 2'b10; end
      ST_MEMRD:    io = 1;
      ST_MEMWB:    begin m2r = 1; rw = 1; end
      ST_MEMWR:    begin io = 1; mw = 1; end
      ST_EXECUTE:  begin
        void'(fn_lookup(f, alu));
        sa = (f == 6'b000000 || f == 6'b000010 || f == 6'b000011) ? 2'b10 : 2'b01;
      end
      ST_ALUWB:    begin rd = 1; rw = 1; end
      ST_BRANCH:   begin sa = 2'b01; alu = 4'b0001; ps = 2'b01; pe = z; end
      ST_ADDIEXEC: begin sa = 2'b01; sb = 2'b10; end
      ST_ADDIWB:   rw = 1;
      ST_JUMP:     begin ps = 2'b10; pe = 1; end
      ST_ILLEGAL:  ill = 1;
      default:     ;
    endcase
    return {st4, alu, sa, sb, ps, io, mw, irw, rd, m2r, rw, pe, ill};
  endfunction

  task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Precondition: just after the edge that entered FETCH
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int exp_ill);
    int ill_seen = 0;
    op = o; funct = f; zero = z;
    build_path(o, f);
    foreach (path_q[i]) begin
      @(negedge clk);
      check($sformatf("op%b_fn%b_step%0d", o, f, i), act, exp_out(path_q[i], f, z));
      if (illegal_instr) ill_seen++;
      @(posedge clk); #1;
    end
    check("back_to_fetch", 22'(state_out), 22'(ST_FETCH));
    check("illegal_pulses", 22'(ill_seen), 22'(exp_ill));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((reg_write && mem_write) || (ir_write && state_out != 4'(ST_FETCH))) begin
        errors++;
        $display("FAIL strobe_invariant: rw=%b mw=%b irw=%b state=%0d", reg_write, mem_write, ir_write, state_out);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  vec_t vecs [11];

  initial begin
    logic [5:0] r_op, r_fn;
    logic [3:0] dummy;
    int r_ill;
    vecs = '{
      '{6'b100011, 6'b000000, 1'b0, 0},  // lw
      '{6'b101011, 6'b000000, 1'b1, 0},  // sw
      '{6'b000000, 6'b100000, 1'b0, 0},  // add
      '{6'b000000, 6'b000011, 1'b0, 0},  // sra
      '{6'b000000, 6'b000000, 1'b1, 0},  // sll
      '{6'b000100, 6'b000000, 1'b1, 0},  // beq taken
      '{6'b000100, 6'b000000, 1'b0, 0},  // beq not taken
      '{6'b001000, 6'b101010, 1'b0, 0},  // addi
      '{6'b000010, 6'b000000, 1'b1, 0},  // j
      '{6'b111111, 6'b000000, 1'b0, 1},  // illegal op
      '{6'b000000, 6'b111111, 1'b0, 1}   // illegal funct
    };

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("in_reset", act, 22'h0);
    rst_n = 1'b1;
    @(negedge clk); check("rst_state_after_release", act, 22'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].ill);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0: r_op = 6'b100011;
        1: r_op = 6'b101011;
        2, 7: r_op = 6'b000000;
        3: r_op = 6'b000100;
        4: r_op = 6'b001000;
        5: r_op = 6'b000010;
        default: r_op = 6'($urandom_range(0, 63));
      endcase
      r_fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : FN_CODE[$urandom_range(0, 12)];
      r_ill = 0;
      if (!(r_op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010}))
        r_ill = 1;
      else if (r_op == 6'b000000 && !fn_lookup(r_fn, dummy))
        r_ill = 1;
      run_instr(r_op, r_fn, 1'($urandom_range(0, 1)), r_ill);
    end

    // Reset asserted while a store is writing memory
    op = 6'b101011; funct = 6'd0; zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("memwr_before_reset", {18'd0, state_out}, {18'd0, 4'(ST_MEMWR)});
    check("mem_write_high", 22'(mem_write), 22'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", act, 22'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); check("rst_state_second", act, 22'h0);
    @(posedge clk); #1;
    run_instr(6'b000000, 6'b100010, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
